rob_commit: RTL and testbench

//  16-entry dual-issue reorder buffer feeding the RegisterFile write ports.

---
 rtl/rob_commit_if.sv | 46 ++++
 rtl/rob_commit.sv | 177 +++++++++++++++++
 tb/tb_rob_commit.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// rtl/rob_commit_if.sv - rename, CDB and commit signal bundle for the reorder buffer
interface rob_commit_if #(
   parameter int DATA_WIDTH     = 16,
   parameter int TAG_WIDTH      = 4,
   parameter int REG_ADDR_WIDTH = 5
);
   // rename side
   logic                      hlt;
   logic [1:0]                alloc_valid;
   logic [REG_ADDR_WIDTH-1:0] alloc_dest1;
   logic [REG_ADDR_WIDTH-1:0] alloc_dest2;
   logic                      alloc_ready;
   logic [TAG_WIDTH-1:0]      alloc_tag1;
   logic [TAG_WIDTH-1:0]      alloc_tag2;

   // completion side
   logic [1:0]                cdb_valid;
   logic [TAG_WIDTH-1:0]      cdb_tag1;
   logic [TAG_WIDTH-1:0]      cdb_tag2;
   logic [DATA_WIDTH-1:0]     cdb_data1;
   logic [DATA_WIDTH-1:0]     cdb_data2;

   // register file write side
   logic [1:0]                regWrite;
   logic [REG_ADDR_WIDTH-1:0] writeAddr1;
   logic [REG_ADDR_WIDTH-1:0] writeAddr2;
   logic [DATA_WIDTH-1:0]     writeData1;
   logic [DATA_WIDTH-1:0]     writeData2;
   logic [TAG_WIDTH:0]        count;

   // rename/CDB/regfile environment
   modport master (
      output hlt, alloc_valid, alloc_dest1, alloc_dest2,
      output cdb_valid, cdb_tag1, cdb_tag2, cdb_data1, cdb_data2,
      input  alloc_ready, alloc_tag1, alloc_tag2,
      input  regWrite, writeAddr1, writeAddr2, writeData1, writeData2, count
   );

   // the reorder buffer itself
   modport slave (
      input  hlt, alloc_valid, alloc_dest1, alloc_dest2,
      input  cdb_valid, cdb_tag1, cdb_tag2, cdb_data1, cdb_data2,
      output alloc_ready, alloc_tag1, alloc_tag2,
      output regWrite, writeAddr1, writeAddr2, writeData1, writeData2, count
   );
endinterface

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - 16-entry dual-issue reorder buffer with in-order dual commit
module rob_commit #(
   parameter int DATA_WIDTH     = 16,
   parameter int TAG_WIDTH      = 4,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic          clk,
   input  logic          rst,
   rob_commit_if.slave   bus
);
   localparam int DEPTH = 1 << TAG_WIDTH;
   localparam int CW    = TAG_WIDTH + 1;

   typedef logic [TAG_WIDTH-1:0]      tag_t;
   typedef logic [REG_ADDR_WIDTH-1:0] reg_t;
   typedef logic [DATA_WIDTH-1:0]     data_t;

   // entry storage
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] done_q, done_d;
   reg_t             dest_q [DEPTH];
   reg_t             dest_d [DEPTH];
   data_t            data_q [DEPTH];
   data_t            data_d [DEPTH];

   // pointers and occupancy
   tag_t             head_q, head_d;
   tag_t             tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   // registered commit port
   logic [1:0]       regwrite_q, regwrite_d;
   reg_t             waddr1_q, waddr1_d;
   reg_t             waddr2_q, waddr2_d;
   data_t            wdata1_q, wdata1_d;
   data_t            wdata2_q, wdata2_d;

   // combinational control
   logic             alloc_ready;
   logic             acc0, acc1;
   tag_t             lane1_tag;
   tag_t             head1;
   logic             c0, c1;
   logic             waw;

   // allocation acceptance uses the pre-edge count; same-cycle commits are not credited
   always_comb begin
      alloc_ready = (count_q <= CW'(DEPTH - 2));
      acc0        = bus.alloc_valid[0] & alloc_ready & ~bus.hlt;
      acc1        = bus.alloc_valid[1] & alloc_ready & ~bus.hlt;
      lane1_tag   = bus.alloc_valid[0] ? tail_q + tag_t'(1) : tail_q;
   end

   // commit decision is taken purely from registered entry state
   always_comb begin
      head1 = head_q + tag_t'(1);
      c0    = valid_q[head_q] & done_q[head_q];
      c1    = c0 & valid_q[head1] & done_q[head1];
      waw   = c1 & (dest_q[head_q] == dest_q[head1]);
   end

   // next entry state: retire, then completion, then allocation
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      dest_d  = dest_q;
      data_d  = data_q;

      if (c0) valid_d[head_q] = 1'b0;
      if (c1) valid_d[head1]  = 1'b0;

      // lane1 is applied last so it wins when both lanes hit one tag
      if (bus.cdb_valid[0] && valid_q[bus.cdb_tag1]) begin
         done_d[bus.cdb_tag1] = 1'b1;
         data_d[bus.cdb_tag1] = bus.cdb_data1;
      end
      if (bus.cdb_valid[1] && valid_q[bus.cdb_tag2]) begin
         done_d[bus.cdb_tag2] = 1'b1;
         data_d[bus.cdb_tag2] = bus.cdb_data2;
      end

      // allocation only ever targets free slots, so it cannot collide with retirement
      if (acc0) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q]  = 1'b0;
         dest_d[tail_q]  = bus.alloc_dest1;
      end
      if (acc1) begin
         valid_d[lane1_tag] = 1'b1;
         done_d[lane1_tag]  = 1'b0;
         dest_d[lane1_tag]  = bus.alloc_dest2;
      end
   end

   // pointer and occupancy bookkeeping
   always_comb begin
      head_d  = head_q + tag_t'(c0) + tag_t'(c1);
      tail_d  = tail_q + tag_t'(acc0) + tag_t'(acc1);
      count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(c0) - CW'(c1);
   end

   // commit port next values; a same-destination pair collapses to one write of the younger result
   always_comb begin
      regwrite_d = waw ? 2'b10 : {c1, c0};
      waddr1_d   = waddr1_q;
      waddr2_d   = waddr2_q;
      wdata1_d   = wdata1_q;
      wdata2_d   = wdata2_q;
      if (waw) begin
         waddr1_d = dest_q[head1];
         wdata1_d = data_q[head1];
         waddr2_d = dest_q[head1];
         wdata2_d = data_q[head1];
      end else begin
         if (c0) begin
            waddr1_d = dest_q[head_q];
            wdata1_d = data_q[head_q];
         end
         if (c1) begin
            waddr2_d = dest_q[head1];
            wdata2_d = data_q[head1];
         end
      end
   end

   // entry array registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         done_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i] <= dest_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   // pointer, count and commit port registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         regwrite_q <= 2'b00;
         waddr1_q   <= '0;
         waddr2_q   <= '0;
         wdata1_q   <= '0;
         wdata2_q   <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         regwrite_q <= regwrite_d;
         waddr1_q   <= waddr1_d;
         waddr2_q   <= waddr2_d;
         wdata1_q   <= wdata1_d;
         wdata2_q   <= wdata2_d;
      end
   end

   assign bus.alloc_ready = alloc_ready;
   assign bus.alloc_tag1  = tail_q;
   assign bus.alloc_tag2  = lane1_tag;
   assign bus.regWrite    = regwrite_q;
   assign bus.writeAddr1  = waddr1_q;
   assign bus.writeAddr2  = waddr2_q;
   assign bus.writeData1  = wdata1_q;
   assign bus.writeData2  = wdata2_q;
   assign bus.count       = count_q;
endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - self-checking bench for rob_commit against a program-order queue model
module tb_rob_commit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rob_commit_if bus ();
   rob_commit dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   // reference model: entries held oldest-first in a queue
   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  dest;
      bit          done;
      logic [15:0] data;
   } ent_t;

   ent_t        mq[$];
   int unsigned mtail;
   logic [1:0]  exp_rw;
   logic [4:0]  exp_a1, exp_a2;
   logic [15:0] exp_d1, exp_d2;
   int          m_n;
   bit          m_rdy;
   ent_t        m_e;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         mtail  = 0;
         exp_rw = 2'b00;
         exp_a1 = '0; exp_a2 = '0; exp_d1 = '0; exp_d2 = '0;
      end else begin
         m_rdy = (16 - mq.size()) >= 2;
         m_n = 0;
         if (mq.size() > 0 && mq[0].done) m_n = 1;
         if (m_n == 1 && mq.size() > 1 && mq[1].done) m_n = 2;
         if (m_n == 2 && mq[0].dest == mq[1].dest) begin
            exp_rw = 2'b10;
            exp_a1 = mq[1].dest;
            exp_d1 = mq[1].data;
         end else begin
            exp_rw = (m_n == 2) ? 2'b11 : (m_n == 1) ? 2'b01 : 2'b00;
            if (m_n >= 1) begin exp_a1 = mq[0].dest; exp_d1 = mq[0].data; end
            if (m_n == 2) begin exp_a2 = mq[1].dest; exp_d2 = mq[1].data; end
         end
         repeat (m_n) void'(mq.pop_front());
         if (bus.cdb_valid[0])
            foreach (mq[i]) if (mq[i].tag == bus.cdb_tag1) begin
               m_e = mq[i]; m_e.done = 1'b1; m_e.data = bus.cdb_data1; mq[i] = m_e;
            end
         if (bus.cdb_valid[1])
            foreach (mq[i]) if (mq[i].tag == bus.cdb_tag2) begin
               m_e = mq[i]; m_e.done = 1'b1; m_e.data = bus.cdb_data2; mq[i] = m_e;
            end
         if (m_rdy && !bus.hlt) begin
            if (bus.alloc_valid[0]) begin
               m_e.tag = 4'(mtail); m_e.dest = bus.alloc_dest1; m_e.done = 1'b0; m_e.data = '0;
               mq.push_back(m_e); mtail++;
            end
            if (bus.alloc_valid[1]) begin
               m_e.tag = 4'(mtail); m_e.dest = bus.alloc_dest2; m_e.done = 1'b0; m_e.data = '0;
               mq.push_back(m_e); mtail++;
            end
         end
      end
   end

   // slot fields are only meaningful where the expected write enables say so
   function automatic logic [53:0] obs_vec();
      logic [4:0]  a1, a2;
      logic [15:0] d1, d2;
      a1 = (exp_rw != 2'b00) ? bus.writeAddr1 : 5'd0;
      d1 = (exp_rw != 2'b00) ? bus.writeData1 : 16'd0;
      a2 = (exp_rw == 2'b11) ? bus.writeAddr2 : 5'd0;
      d2 = (exp_rw == 2'b11) ? bus.writeData2 : 16'd0;
      return {bus.regWrite, a1, d1, a2, d2, bus.count, bus.alloc_ready, bus.alloc_tag1};
   endfunction

   function automatic logic [53:0] exp_vec();
      logic [4:0]  a1, a2;
      logic [15:0] d1, d2;
      logic        rdy;
      a1  = (exp_rw != 2'b00) ? exp_a1 : 5'd0;
      d1  = (exp_rw != 2'b00) ? exp_d1 : 16'd0;
      a2  = (exp_rw == 2'b11) ? exp_a2 : 5'd0;
      d2  = (exp_rw == 2'b11) ? exp_d2 : 16'd0;
      rdy = (mq.size() <= 14);
      return {exp_rw, a1, d1, a2, d2, 5'(mq.size()), rdy, 4'(mtail)};
   endfunction

   task automatic drive(input logic [1:0] av, input logic [4:0] d1, input logic [4:0] d2,
                        input logic [1:0] cv, input logic [3:0] t1, input logic [3:0] t2,
                        input logic [15:0] x1, input logic [15:0] x2, input logic h);
      bus.alloc_valid = av;  bus.alloc_dest1 = d1; bus.alloc_dest2 = d2;
      bus.cdb_valid   = cv;  bus.cdb_tag1    = t1; bus.cdb_tag2    = t2;
      bus.cdb_data1   = x1;  bus.cdb_data2   = x2; bus.hlt         = h;
   endtask

   task automatic idle();
      drive(2'b00, 5'd0, 5'd0, 2'b00, 4'd0, 4'd0, 16'd0, 16'd0, 1'b0);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      repeat (2) tick();
      checks++;
      if ({bus.regWrite, bus.writeAddr1, bus.writeData1, bus.writeAddr2, bus.writeData2,
           bus.count, bus.alloc_ready, bus.alloc_tag1} !== {2'b00, 5'd0, 16'd0, 5'd0, 16'd0, 5'd0, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL reset_state: got rw=%b cnt=%0d rdy=%b tag=%0d", bus.regWrite, bus.count, bus.alloc_ready, bus.alloc_tag1);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      drive(2'b11, 5'd3, 5'd4, 2'b00, 4'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      #1;
      checks++;
      if ({bus.alloc_tag1, bus.alloc_tag2} !== {4'd0, 4'd1}) begin
         errors++; $display("FAIL basic_tags: got %0d/%0d required 0/1", bus.alloc_tag1, bus.alloc_tag2);
      end
      tick(); idle();
      checks++;
      if (bus.count !== 5'd2) begin errors++; $display("FAIL basic_count: got %0d required 2", bus.count); end
      drive(2'b00, 5'd0, 5'd0, 2'b11, 4'd0, 4'd1, 16'h00AA, 16'h00BB, 1'b0);
      tick(); idle();
      checks++;
      if (bus.regWrite !== 2'b00) begin errors++; $display("FAIL basic_early: got %b required 00", bus.regWrite); end
      tick();
      checks++;
      if ({bus.regWrite, bus.writeAddr1, bus.writeAddr2, bus.writeData1, bus.writeData2, bus.count}
          !== {2'b11, 5'd3, 5'd4, 16'h00AA, 16'h00BB, 5'd0}) begin
         errors++;
         $display("FAIL basic_commit: got rw=%b a=%0d/%0d d=%h/%h cnt=%0d", bus.regWrite, bus.writeAddr1,
                  bus.writeAddr2, bus.writeData1, bus.writeData2, bus.count);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL basic_model: got %h required %h", obs_vec(), exp_vec()); end
   endtask

   task automatic test_in_order();
      drive(2'b11, 5'd5, 5'd6, 2'b00, 4'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      tick(); idle();
      drive(2'b00, 5'd0, 5'd0, 2'b01, 4'd3, 4'd0, 16'h0033, 16'd0, 1'b0);
      tick(); idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({bus.regWrite, bus.count} !== {2'b00, 5'd2}) begin
            errors++; $display("FAIL order_hold: got rw=%b cnt=%0d required 00/2", bus.regWrite, bus.count);
         end
      end
      drive(2'b00, 5'd0, 5'd0, 2'b10, 4'd0, 4'd2, 16'd0, 16'h0022, 1'b0);
      tick(); idle();
      tick();
      checks++;
      if ({bus.regWrite, bus.writeAddr1, bus.writeAddr2, bus.writeData1, bus.writeData2}
          !== {2'b11, 5'd5, 5'd6, 16'h0022, 16'h0033}) begin
         errors++; $display("FAIL order_commit: got rw=%b d=%h/%h", bus.regWrite, bus.writeData1, bus.writeData2);
      end
   endtask

   task automatic test_full_wrap();
      int unsigned idx0, idx1;
      for (int k = 0; k < 7; k++) begin
         drive(2'b11, 5'(k), 5'(k + 8), 2'b00, 4'd0, 4'd0, 16'd0, 16'd0, 1'b0);
         #1;
         checks++;
         if ({bus.alloc_tag1, bus.alloc_tag2} !== {4'((4 + 2 * k) % 16), 4'((5 + 2 * k) % 16)}) begin
            errors++; $display("FAIL fill_tags%0d: got %0d/%0d", k, bus.alloc_tag1, bus.alloc_tag2);
         end
         tick(); idle();
      end
      checks++;
      if ({bus.count, bus.alloc_ready} !== {5'd14, 1'b1}) begin
         errors++; $display("FAIL fill_14: got cnt=%0d rdy=%b required 14/1", bus.count, bus.alloc_ready);
      end
      drive(2'b10, 5'd0, 5'd20, 2'b00, 4'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      #1;
      checks++;
      if (bus.alloc_tag2 !== 4'd2) begin errors++; $display("FAIL lane1_only_tag: got %0d required 2", bus.alloc_tag2); end
      tick(); idle();
      checks++;
      if ({bus.count, bus.alloc_ready} !== {5'd15, 1'b0}) begin
         errors++; $display("FAIL fill_15: got cnt=%0d rdy=%b required 15/0", bus.count, bus.alloc_ready);
      end
      drive(2'b11, 5'd1, 5'd2, 2'b00, 4'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      tick(); idle();
      checks++;
      if ({bus.count, bus.alloc_tag1} !== {5'd15, 4'd3}) begin
         errors++; $display("FAIL full_drop: got cnt=%0d tag=%0d required 15/3", bus.count, bus.alloc_tag1);
      end
      for (int c = 0; c < 40; c++) begin
         if (mq.size() > 0) begin
            idx0 = $urandom_range(0, mq.size() - 1);
            idx1 = $urandom_range(0, mq.size() - 1);
            drive(2'b00, 5'd0, 5'd0, 2'b11, mq[idx0].tag, mq[idx1].tag, 16'($urandom), 16'($urandom), 1'b0);
         end else idle();
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL drain_c%0d: got %h required %h", c, obs_vec(), exp_vec()); end
      end
      idle();
      checks++;
      if (bus.count !== 5'd0) begin errors++; $display("FAIL drain_empty: got %0d required 0", bus.count); end
   endtask

   task automatic test_waw();
      logic [3:0] t;
      t = 4'(mtail);
      drive(2'b11, 5'd7, 5'd7, 2'b00, 4'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      tick(); idle();
      drive(2'b00, 5'd0, 5'd0, 2'b11, t, t + 4'd1, 16'd5, 16'd9, 1'b0);
      tick(); idle();
      tick();
      checks++;
      if ({bus.regWrite, bus.writeAddr1, bus.writeData1, bus.count} !== {2'b10, 5'd7, 16'd9, 5'd0}) begin
         errors++; $display("FAIL waw: got rw=%b a1=%0d d1=%0d cnt=%0d required 10/7/9/0",
                            bus.regWrite, bus.writeAddr1, bus.writeData1, bus.count);
      end
      tick();
      checks++;
      if (bus.regWrite !== 2'b00) begin errors++; $display("FAIL waw_idle: got %b required 00", bus.regWrite); end
   endtask

   task automatic test_hlt();
      logic [3:0] t0;
      drive(2'b11, 5'd1, 5'd2, 2'b00, 4'd0, 4'd0, 16'd0, 16'd0, 1'b0);
      tick(); idle();
      t0 = 4'(mtail);
      drive(2'b11, 5'd9, 5'd10, 2'b11, mq[0].tag, mq[1].tag, 16'h0111, 16'h0222, 1'b1);
      tick(); idle(); bus.hlt = 1'b1;
      checks++;
      if ({bus.count, bus.alloc_tag1} !== {5'd2, t0}) begin
         errors++; $display("FAIL hlt_block: got cnt=%0d tag=%0d required 2/%0d", bus.count, bus.alloc_tag1, t0);
      end
      tick();
      checks++;
      if ({bus.regWrite, bus.writeAddr1, bus.writeAddr2, bus.writeData1, bus.writeData2, bus.count, bus.alloc_tag1}
          !== {2'b11, 5'd1, 5'd2, 16'h0111, 16'h0222, 5'd0, t0}) begin
         errors++; $display("FAIL hlt_commit: got rw=%b d=%h/%h cnt=%0d", bus.regWrite, bus.writeData1, bus.writeData2, bus.count);
      end
      bus.hlt = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] b;
      b = 4'(mtail);
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 5'(k + 11), 5'(k + 21), 2'b00, 4'd0, 4'd0, 16'd0, 16'd0, 1'b0);
         tick(); idle();
      end
      drive(2'b00, 5'd0, 5'd0, 2'b11, b, b + 4'd1, 16'h0C0C, 16'h0D0D, 1'b0);
      tick(); idle();
      tick();
      checks++;
      if ({bus.regWrite, bus.count} !== {2'b11, 5'd6}) begin
         errors++; $display("FAIL pre_reset: got rw=%b cnt=%0d required 11/6", bus.regWrite, bus.count);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({bus.regWrite, bus.count, bus.alloc_ready, bus.alloc_tag1, bus.writeAddr1, bus.writeData1}
          !== {2'b00, 5'd0, 1'b1, 4'd0, 5'd0, 16'd0}) begin
         errors++; $display("FAIL async_reset: got rw=%b cnt=%0d rdy=%b", bus.regWrite, bus.count, bus.alloc_ready);
      end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(2'b00, 5'd0, 5'd0, 2'b11, b + 4'(2 * k + 2), b + 4'(2 * k + 3), 16'hFFFF, 16'hEEEE, 1'b0);
         tick();
      end
      idle();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if ({bus.regWrite, bus.count} !== {2'b00, 5'd0}) begin
            errors++; $display("FAIL stale_cdb%0d: got rw=%b cnt=%0d required 00/0", k, bus.regWrite, bus.count);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] t1, t2;
      for (int c = 0; c < 400; c++) begin
         t1 = 4'($urandom);
         t2 = 4'($urandom);
         if (mq.size() > 0 && $urandom_range(0, 7) != 0) t1 = mq[$urandom_range(0, mq.size() - 1)].tag;
         if (mq.size() > 0 && $urandom_range(0, 7) != 0) t2 = mq[$urandom_range(0, mq.size() - 1)].tag;
         drive(2'($urandom), 5'($urandom), 5'($urandom), 2'($urandom), t1, t2,
               16'($urandom), 16'($urandom), $urandom_range(0, 9) == 0);
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random_c%0d: got %h required %h", c, obs_vec(), exp_vec()); end
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_in_order();
      test_full_wrap();
      test_waw();
      test_hlt();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
